// File: rtl/picorv32_axil_pkg.sv
// Shared types and constants for the PicoRV32 native-to-AXI-lite bridge.
// Holds the FSM state encoding, AXI response codes and PROT values.
package picorv32_axil_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WR       = 3'd1,
        ST_WR_RESP  = 3'd2,
        ST_RD_ADDR  = 3'd3,
        ST_RD_DATA  = 3'd4,
        ST_DONE     = 3'd5
    } state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [2:0] PROT_DATA  = 3'b000;
    localparam logic [2:0] PROT_INSTR = 3'b100;

    // EXOKAY has no meaning on AXI-lite, so anything but OKAY is an error.
    function automatic logic resp_is_error(input logic [1:0] resp);
        return (resp == RESP_SLVERR) || (resp == RESP_DECERR) || (resp == RESP_EXOKAY);
    endfunction

endpackage

// File: rtl/picorv32_axil_bridge.sv
// PicoRV32 native memory port to single-outstanding AXI-lite master.
// One AXI transaction per mem_valid request; sticky error status with first-error address.
module picorv32_axil_bridge
    import picorv32_axil_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  resetn,

    input  logic                  mem_valid,
    input  logic                  mem_instr,
    output logic                  mem_ready,
    input  logic [31:0]           mem_addr,
    input  logic [31:0]           mem_wdata,
    input  logic [3:0]            mem_wstrb,
    output logic [31:0]           mem_rdata,

    output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
    output logic [2:0]            m_axi_awprot,
    output logic                  m_axi_awvalid,
    input  logic                  m_axi_awready,

    output logic [31:0]           m_axi_wdata,
    output logic [3:0]            m_axi_wstrb,
    output logic                  m_axi_wvalid,
    input  logic                  m_axi_wready,

    input  logic [1:0]            m_axi_bresp,
    input  logic                  m_axi_bvalid,
    output logic                  m_axi_bready,

    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [2:0]            m_axi_arprot,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,

    input  logic [31:0]           m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready,

    output logic                  err_flag,
    output logic [ADDR_WIDTH-1:0] err_addr
);

    state_e                state_q,    state_d;
    logic [ADDR_WIDTH-1:0] addr_q,     addr_d;
    logic [31:0]           wdata_q,    wdata_d;
    logic [3:0]            wstrb_q,    wstrb_d;
    logic                  instr_q,    instr_d;
    logic                  awvalid_q,  awvalid_d;
    logic                  wvalid_q,   wvalid_d;
    logic                  aw_done_q,  aw_done_d;
    logic                  w_done_q,   w_done_d;
    logic                  bready_q,   bready_d;
    logic                  arvalid_q,  arvalid_d;
    logic                  rready_q,   rready_d;
    logic                  mready_q,   mready_d;
    logic [31:0]           rdata_q,    rdata_d;
    logic                  err_flag_q, err_flag_d;
    logic [ADDR_WIDTH-1:0] err_addr_q, err_addr_d;

    logic aw_fire;
    logic w_fire;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            instr_q    <= 1'b0;
            awvalid_q  <= 1'b0;
            wvalid_q   <= 1'b0;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
            bready_q   <= 1'b0;
            arvalid_q  <= 1'b0;
            rready_q   <= 1'b0;
            mready_q   <= 1'b0;
            rdata_q    <= '0;
            err_flag_q <= 1'b0;
            err_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            instr_q    <= instr_d;
            awvalid_q  <= awvalid_d;
            wvalid_q   <= wvalid_d;
            aw_done_q  <= aw_done_d;
            w_done_q   <= w_done_d;
            bready_q   <= bready_d;
            arvalid_q  <= arvalid_d;
            rready_q   <= rready_d;
            mready_q   <= mready_d;
            rdata_q    <= rdata_d;
            err_flag_q <= err_flag_d;
            err_addr_q <= err_addr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        instr_d    = instr_q;
        awvalid_d  = awvalid_q;
        wvalid_d   = wvalid_q;
        aw_done_d  = aw_done_q;
        w_done_d   = w_done_q;
        bready_d   = bready_q;
        arvalid_d  = arvalid_q;
        rready_d   = rready_q;
        mready_d   = 1'b0;
        rdata_d    = rdata_q;
        err_flag_d = err_flag_q;
        err_addr_d = err_addr_q;

        aw_fire = awvalid_q && m_axi_awready;
        w_fire  = wvalid_q && m_axi_wready;

        unique case (state_q)
            ST_IDLE: begin
                if (mem_valid) begin
                    addr_d  = mem_addr[ADDR_WIDTH-1:0];
                    wdata_d = mem_wdata;
                    wstrb_d = mem_wstrb;
                    instr_d = mem_instr;
                    if (mem_wstrb != 4'b0000) begin
                        state_d   = ST_WR;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        aw_done_d = 1'b0;
                        w_done_d  = 1'b0;
                    end else begin
                        state_d   = ST_RD_ADDR;
                        arvalid_d = 1'b1;
                    end
                end
            end

            // AW and W retire independently; leave once both have handshaken.
            ST_WR: begin
                if (aw_fire) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (w_fire) begin
                    wvalid_d = 1'b0;
                    w_done_d = 1'b1;
                end
                if ((aw_done_q || aw_fire) && (w_done_q || w_fire)) begin
                    state_d  = ST_WR_RESP;
                    bready_d = 1'b1;
                end
            end

            ST_WR_RESP: begin
                if (m_axi_bvalid) begin
                    bready_d = 1'b0;
                    mready_d = 1'b1;
                    state_d  = ST_DONE;
                    if (resp_is_error(m_axi_bresp) && !err_flag_q) begin
                        err_flag_d = 1'b1;
                        err_addr_d = addr_q;
                    end
                end
            end

            ST_RD_ADDR: begin
                if (m_axi_arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = ST_RD_DATA;
                end
            end

            ST_RD_DATA: begin
                if (m_axi_rvalid) begin
                    rready_d = 1'b0;
                    rdata_d  = m_axi_rdata;
                    mready_d = 1'b1;
                    state_d  = ST_DONE;
                    if (resp_is_error(m_axi_rresp) && !err_flag_q) begin
                        err_flag_d = 1'b1;
                        err_addr_d = addr_q;
                    end
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign mem_ready     = mready_q;
    assign mem_rdata     = rdata_q;

    assign m_axi_awaddr  = addr_q;
    assign m_axi_awprot  = PROT_DATA;
    assign m_axi_awvalid = awvalid_q;

    assign m_axi_wdata   = wdata_q;
    assign m_axi_wstrb   = wstrb_q;
    assign m_axi_wvalid  = wvalid_q;

    assign m_axi_bready  = bready_q;

    assign m_axi_araddr  = addr_q;
    assign m_axi_arprot  = instr_q ? PROT_INSTR : PROT_DATA;
    assign m_axi_arvalid = arvalid_q;

    assign m_axi_rready  = rready_q;

    assign err_flag      = err_flag_q;
    assign err_addr      = err_addr_q;

endmodule
